// File: rtl/if_fetch_sequencer_pkg.sv
// if_fetch_sequencer_pkg: shared FSM encoding, constants and helpers for the IF fetch sequencer
package if_fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD,
      S_DISCARD
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_STEP_DEF  = 32'd4;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/if_next_pc_sel.sv
// if_next_pc_sel: priority next-PC select (branch over jump over sequential) with target alignment
module if_next_pc_sel
   import if_fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] PC_STEP = PC_STEP_DEF
) (
   input  logic [31:0] fetch_pc,
   input  logic        pcsrc,
   input  logic [31:0] branch_dest,
   input  logic        jump,
   input  logic [31:0] jump_dest,
   output logic        redirect,
   output logic        branch,
   output logic [31:0] next_pc
);

   // The branch in MEM is older than the jump in ID, so it wins.
   always_comb begin
      redirect = pcsrc | jump;
      branch   = pcsrc;
      next_pc  = pcsrc ? word_align(branch_dest) : jump ? word_align(jump_dest) : fetch_pc + PC_STEP;
   end

endmodule

// File: rtl/if_fetch_sequencer.sv
// if_fetch_sequencer: fetch PC owner, single-outstanding imem handshake and IF/ID instruction buffer
module if_fetch_sequencer
   import if_fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall_IF,
   input  logic        Jump_Control_ID,
   input  logic [31:0] Jump_Dest_ID,
   input  logic        PCSrc_MEM,
   input  logic [31:0] Branch_Dest_MEM,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr_IF,
   output logic        Instr_Valid_IF,
   output logic [31:0] PC_IF,
   output logic [31:0] PC_Plus_4_IF,
   output logic        Flush_IFID,
   output logic        Flush_IDEX
);

   fetch_state_t state;
   logic [31:0]  fetch_pc;
   logic [31:0]  hold_word;
   logic [31:0]  next_pc;
   logic         redirect;
   logic         branch;
   logic         consume;
   logic         buf_free;
   logic         drain;

   if_next_pc_sel #(.PC_STEP(PC_STEP)) u_next_pc_sel (
      .fetch_pc    (fetch_pc),
      .pcsrc       (PCSrc_MEM),
      .branch_dest (Branch_Dest_MEM),
      .jump        (Jump_Control_ID),
      .jump_dest   (Jump_Dest_ID),
      .redirect    (redirect),
      .branch      (branch),
      .next_pc     (next_pc)
   );

   assign imem_addr    = fetch_pc;
   assign PC_Plus_4_IF = PC_IF + PC_STEP;

   // Buffer hand-off and whether a redirect still leaves a response in flight to drop.
   always_comb begin
      consume  = Instr_Valid_IF & ~Stall_IF;
      buf_free = ~Instr_Valid_IF | ~Stall_IF;
      drain    = (state == S_FETCH & imem_gnt) |
                 ((state == S_WAIT | state == S_DISCARD) & ~imem_rvalid);
   end

   // Fetch FSM with PC, instruction buffer, hold register and flush pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         fetch_pc       <= RESET_PC;
         PC_IF          <= RESET_PC;
         Instr_IF       <= NOP_INSTR;
         Instr_Valid_IF <= 1'b0;
         hold_word      <= NOP_INSTR;
         imem_req       <= 1'b0;
         Flush_IFID     <= 1'b0;
         Flush_IDEX     <= 1'b0;
      end else begin
         Flush_IFID <= redirect;
         Flush_IDEX <= redirect & branch;
         if (consume) Instr_Valid_IF <= 1'b0;
         if (redirect) begin
            fetch_pc       <= next_pc;
            Instr_Valid_IF <= 1'b0;
            state          <= drain ? S_DISCARD : S_FETCH;
            imem_req       <= ~drain;
         end else begin
            case (state)
               S_IDLE: begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
               end
               S_FETCH: begin
                  if (imem_gnt) begin
                     state    <= S_WAIT;
                     imem_req <= 1'b0;
                  end
               end
               S_WAIT: begin
                  if (imem_rvalid && buf_free) begin
                     Instr_IF       <= imem_rdata;
                     PC_IF          <= fetch_pc;
                     Instr_Valid_IF <= 1'b1;
                     fetch_pc       <= next_pc;
                     state          <= S_FETCH;
                     imem_req       <= 1'b1;
                  end else if (imem_rvalid) begin
                     hold_word <= imem_rdata;
                     state     <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (consume) begin
                     Instr_IF       <= hold_word;
                     PC_IF          <= fetch_pc;
                     Instr_Valid_IF <= 1'b1;
                     fetch_pc       <= next_pc;
                     state          <= S_FETCH;
                     imem_req       <= 1'b1;
                  end
               end
               S_DISCARD: begin
                  if (imem_rvalid) begin
                     state    <= S_FETCH;
                     imem_req <= 1'b1;
                  end
               end
               default: begin
                  state    <= S_IDLE;
                  imem_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// tb_if_fetch_sequencer: randomized bench with a transaction-level fetch model and directed scenarios
module tb_if_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Stall_IF = 1'b0;
   logic        Jump_Control_ID = 1'b0;
   logic [31:0] Jump_Dest_ID = '0;
   logic        PCSrc_MEM = 1'b0;
   logic [31:0] Branch_Dest_MEM = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] Instr_IF;
   logic        Instr_Valid_IF;
   logic [31:0] PC_IF;
   logic [31:0] PC_Plus_4_IF;
   logic        Flush_IFID;
   logic        Flush_IDEX;

   if_fetch_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .Stall_IF        (Stall_IF),
      .Jump_Control_ID (Jump_Control_ID),
      .Jump_Dest_ID    (Jump_Dest_ID),
      .PCSrc_MEM       (PCSrc_MEM),
      .Branch_Dest_MEM (Branch_Dest_MEM),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .Instr_IF        (Instr_IF),
      .Instr_Valid_IF  (Instr_Valid_IF),
      .PC_IF           (PC_IF),
      .PC_Plus_4_IF    (PC_Plus_4_IF),
      .Flush_IFID      (Flush_IFID),
      .Flush_IDEX      (Flush_IDEX)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Memory: one outstanding request, grant probability p_gnt, latency lat_fix or random 1..3.
   int          p_gnt = 100;
   int          lat_fix = 1;
   bit          busy = 1'b0;
   int          cnt = 0;
   logic [31:0] maddr = '0;
   bit          g_req = 1'b0;
   bit          g_gnt = 1'b0;
   logic [31:0] g_addr = '0;

   task automatic step();
      @(posedge clk);
      #1;
      if (g_req && g_gnt) begin
         busy  = 1'b1;
         cnt   = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
         maddr = g_addr;
      end
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (busy) begin
         cnt--;
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(maddr);
            busy        = 1'b0;
         end
      end
      imem_gnt = imem_req && !busy && ($urandom_range(0, 99) < p_gnt);
      g_req  = imem_req;
      g_gnt  = imem_gnt;
      g_addr = imem_addr;
   endtask

   // Transaction-level model: a request is presented whenever nothing is in flight and
   // nothing is parked; responses either fill the buffer, park, or are dropped if stale.
   bit          m_req, m_out, m_live, m_buf_v, m_hold_v, m_fl_ifid, m_fl_idex;
   logic [31:0] m_addr, m_out_addr, m_buf_d, m_buf_pc, m_hold_pc;
   bit          t_redir, t_consume, t_free, t_resp, t_gnt;
   logic [31:0] t_tgt;

   always @(posedge clk) begin
      if (reset) begin
         m_req = 0; m_out = 0; m_live = 0; m_buf_v = 0; m_hold_v = 0;
         m_fl_ifid = 0; m_fl_idex = 0;
         m_addr = 32'h0; m_buf_d = 32'h0; m_buf_pc = 32'h0; m_out_addr = 32'h0; m_hold_pc = 32'h0;
      end else begin
         t_redir   = PCSrc_MEM | Jump_Control_ID;
         t_tgt     = (PCSrc_MEM ? Branch_Dest_MEM : Jump_Dest_ID) & 32'hFFFF_FFFC;
         t_consume = m_buf_v & ~Stall_IF;
         t_free    = ~m_buf_v | ~Stall_IF;
         t_resp    = m_out & imem_rvalid;
         t_gnt     = m_req & imem_gnt;
         m_fl_ifid = t_redir;
         m_fl_idex = PCSrc_MEM;
         if (t_consume) m_buf_v = 0;
         if (t_gnt) begin
            m_out_addr = m_addr;
            m_live = 1;
         end
         if (!t_redir && t_resp && m_live) begin
            if (t_free) begin
               m_buf_v = 1; m_buf_d = mem_word(m_out_addr); m_buf_pc = m_out_addr;
               m_addr = m_out_addr + 32'd4;
            end else begin
               m_hold_v = 1; m_hold_pc = m_out_addr;
            end
         end else if (!t_redir && m_hold_v && t_consume) begin
            m_buf_v = 1; m_buf_d = mem_word(m_hold_pc); m_buf_pc = m_hold_pc;
            m_addr = m_hold_pc + 32'd4;
            m_hold_v = 0;
         end
         m_out = (m_out & ~imem_rvalid) | t_gnt;
         if (t_redir) begin
            m_addr = t_tgt; m_buf_v = 0; m_hold_v = 0; m_live = 0;
         end
         m_req = ~m_out & ~m_hold_v;
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", imem_req, m_req);
         if (m_req) chk("imem_addr", imem_addr, m_addr);
         chk("instr_valid", Instr_Valid_IF, m_buf_v);
         if (m_buf_v) begin
            chk("instr", Instr_IF, m_buf_d);
            chk("pc_if", PC_IF, m_buf_pc);
            chk("pc_plus_4", PC_Plus_4_IF, m_buf_pc + 32'd4);
         end
         chk("flush_ifid", Flush_IFID, m_fl_ifid);
         chk("flush_idex", Flush_IDEX, m_fl_idex);
      end
   end

   function automatic logic [31:0] rnd_target();
      return ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
   endfunction

   initial begin
      reset = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_req", imem_req, 0);
      chk("rst_valid", Instr_Valid_IF, 0);
      chk("rst_instr", Instr_IF, 32'h0);
      chk("rst_pc", PC_IF, 32'h0);
      chk("rst_flush", {Flush_IFID, Flush_IDEX}, 0);

      // Sequential fetch with immediate grant and one-cycle latency.
      reset = 1'b0;
      for (int i = 0; i < 20 && !Instr_Valid_IF; i++) step();
      chk("seq0_valid", Instr_Valid_IF, 1);
      chk("seq0_pc", PC_IF, 32'h0);
      chk("seq0_pc4", PC_Plus_4_IF, 32'h4);
      chk("seq0_instr", Instr_IF, mem_word(32'h0));
      step(); step();
      chk("seq1_pc", PC_IF, 32'h4);
      chk("seq1_valid", Instr_Valid_IF, 1);

      // Stall while 0x4 is presented; 0x8 must park and appear right after the stall drops.
      Stall_IF = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_pc", PC_IF, 32'h4);
         chk("stall_valid", Instr_Valid_IF, 1);
      end
      Stall_IF = 1'b0;
      step();
      chk("unstall_pc", PC_IF, 32'h8);
      chk("unstall_instr", Instr_IF, mem_word(32'h8));

      // Jump while waiting on a slow response: response dropped, refetch at 0x100.
      lat_fix = 3;
      step();
      chk("wait_req", imem_req, 0);
      Jump_Control_ID = 1'b1;
      Jump_Dest_ID    = 32'h100;
      step();
      Jump_Control_ID = 1'b0;
      chk("jump_fl_ifid", Flush_IFID, 1);
      chk("jump_fl_idex", Flush_IDEX, 0);
      step();
      chk("jump_fl_once", Flush_IFID, 0);
      p_gnt = 0;
      for (int i = 0; i < 20 && !imem_req; i++) step();
      chk("jump_req", imem_req, 1);
      chk("jump_addr", imem_addr, 32'h100);
      chk("jump_no_instr", Instr_Valid_IF, 0);

      // Branch and jump together: branch wins, both flushes pulse.
      PCSrc_MEM = 1'b1; Branch_Dest_MEM = 32'h200;
      Jump_Control_ID = 1'b1; Jump_Dest_ID = 32'h300;
      step();
      Jump_Control_ID = 1'b0;
      chk("bj_addr", imem_addr, 32'h200);
      chk("bj_flush", {Flush_IFID, Flush_IDEX}, 2'b11);

      // Misaligned branch target with grant withheld; back-to-back redirect repeats the flush.
      Branch_Dest_MEM = 32'h203;
      step();
      PCSrc_MEM = 1'b0;
      chk("b2b_flush", {Flush_IFID, Flush_IDEX}, 2'b11);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("nognt_req", imem_req, 1);
         chk("nognt_addr", imem_addr, 32'h200);
      end

      // Wrap from the top of the address space.
      PCSrc_MEM = 1'b1; Branch_Dest_MEM = 32'hFFFF_FFFE;
      step();
      PCSrc_MEM = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      p_gnt = 100; lat_fix = 1;
      for (int i = 0; i < 20 && !Instr_Valid_IF; i++) step();
      chk("wrap_pc", PC_IF, 32'hFFFF_FFFC);
      chk("wrap_next", imem_addr, 32'h0);

      // Reset while a response is in flight; first fetch afterwards is from RESET_PC.
      lat_fix = 3;
      for (int i = 0; i < 20 && imem_req; i++) step();
      chk("rw_wait", imem_req, 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("rw_valid", Instr_Valid_IF, 0);
      chk("rw_pc", PC_IF, 32'h0);
      chk("rw_instr", Instr_IF, 32'h0);
      reset = 1'b0;
      lat_fix = 1;
      for (int i = 0; i < 20 && !Instr_Valid_IF; i++) step();
      chk("rw_first_pc", PC_IF, 32'h0);
      chk("rw_first_instr", Instr_IF, mem_word(32'h0));

      // Random traffic against the model.
      lat_fix = 0; p_gnt = 60;
      for (int i = 0; i < 4000; i++) begin
         reset           = ($urandom_range(0, 299) == 0);
         Stall_IF        = ($urandom_range(0, 99) < 30);
         Jump_Control_ID = ($urandom_range(0, 99) < 6);
         PCSrc_MEM       = ($urandom_range(0, 99) < 4);
         Jump_Dest_ID    = rnd_target();
         Branch_Dest_MEM = rnd_target();
         step();
      end
      reset = 1'b0; Stall_IF = 1'b0; Jump_Control_ID = 1'b0; PCSrc_MEM = 1'b0;
      for (int i = 0; i < 10; i++) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
